vga_glyph_renderer: RTL and testbench
=====================================

// Module: vga_glyph_renderer
// PURPOSE
//  Text-mode VGA front end that consumes the character display RAM's VGA read port.
//  - Generates 640x480@60 timing (800x525 total) from a divided pixel tick.
//  - Drives glyph row/column addresses and receives the 7-bit character code combinationally.
//  - Expands each code through an 8x8 font ROM and outputs pixels, with sync aligned to pixel data.
// PARAMETERS
//  CLK_DIV   2    system clocks per pixel tick (50 MHz clk -> 25 MHz pixel rate)
//  H_ACTIVE  640  visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
//  V_ACTIVE  480  visible lines; V_FP 10, V_SYNC 2, V_BP 33 (frame total 525)
//  FG_COLOR  8'hFF  RGB332 colour driven for a set font bit
//  BG_COLOR  8'h00  RGB332 colour driven for a clear font bit inside the active area
// PORTS
//  clk         in   1   system clock; all state changes on posedge
//  reset       in   1   asynchronous, active-high; clears all state
//  charCode    in   7   character code returned by the display RAM for {vGlyphVGA,hGlyphVGA}
//  hGlyphVGA   out  8   glyph column address, 0..79
//  vGlyphVGA   out  7   glyph row address, 0..59
//  hSync       out  1   horizontal sync, active-low
//  vSync       out  1   vertical sync, active-low
//  rgb         out  8   RGB332 pixel; 0 outside the active area
//  frameStart  out  1   one-clk pulse on the tick where the counters wrap to (0,0)
// BEHAVIOUR
//  Reset values
//  - Divider, hCount, vCount and all pipeline registers reset to 0.
//  - hSync = vSync = 1; rgb = 0; frameStart = 0. Reset may be asserted mid-frame.
//  - After release, the first tick occurs CLK_DIV clocks later and timing restarts at (0,0).
//  Pixel tick
//  - tick = 1 for one clk when the divider reaches CLK_DIV-1; the divider then wraps to 0.
//  - All counters and pipeline registers advance only on tick.
//  Counters
//  - hCount runs 0..799; at 799 it wraps to 0 and vCount increments.
//  - vCount runs 0..524; at (799,524) both counters wrap to 0 and frameStart pulses.
//  - active = (hCount < 640) && (vCount < 480).
//  Stage 0 (combinational)
//  - hGlyphVGA = active ? {1'b0, hCount[9:3]} : 0.
//  - vGlyphVGA = active ? {1'b0, vCount[8:3]} : 0.
//  - charCode is valid in the same clk because the RAM read is asynchronous.
//  - Register on tick: charCode, hCount[2:0], vCount[2:0], active, rawH, rawV.
//    rawH = !(656 <= hCount < 752); rawV = !(490 <= vCount < 492).
//  Stage 1 (font ROM)
//  - Synchronous ROM read at address {code, vRow} (10 bits), enabled on tick, returns 8-bit row.
//  - The column, active and sync bits are delayed one more stage alongside the ROM read.
//  Stage 2 (output)
//  - bit = row[7 - col]; register on tick: rgb = active ? (bit ? FG : BG) : 0.
//  - Register hSync and vSync from the delayed rawH and rawV.
//  - rgb, hSync and vSync change together, exactly 3 ticks after the counter value that produced them.
//  - frameStart is not pipelined; it marks the counter wrap.
//  - Simultaneous h and v wrap: vCount wraps to 0 and no increment is applied.
//  - The CPU writing the same RAM cell is invisible here; the new code appears from the next tick's read.
// STRUCTURE
//  - Shared package vga_timing_pkg holds H_*/V_* constants, totals, sync start/end values,
//    GLYPH_W = GLYPH_H = 8, COLS = 80, ROWS = 60.
//  - Sub-module glyph_font_rom: 1024x8 memory loaded by $readmemb("glyphFont.dat"),
//    ports clk, en, addr[9:0], row[7:0], read latency 1.
//  - Everything else lives in this module: divider, counters, 3-stage pipeline.
// TESTING
//  1 Reset mid-frame at (300,200) -> next clk: rgb=0, hSync=vSync=1;
//    first tick after release has hCount=0, vCount=0.
//  2 Counter at (639,479) -> hGlyphVGA=79, vGlyphVGA=59;
//    at (640,0) -> both 0 and rgb=0 three ticks later.
//  3 hSync -> low for exactly 96 ticks, first low at counter tick 656+3; vSync low for 2 lines at 490..491.
//  4 charCode=7'h41, ROM row 3 = 8'b0011_1100 at (16..23,3)
//    -> rgb sequence 00,00,FF,FF,FF,FF,00,00, each 3 ticks late.
//  5 Full frame -> exactly 800*525 ticks between frameStart pulses;
//    CLK_DIV=2 gives 840000 clks.
//  6 Change charCode mid-glyph at hCount=20
//    -> pixels from hCount 20 onward use the new code's row; earlier pixels are unaffected.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 text-mode timing constants, glyph geometry and the
// pipeline record types used by the glyph renderer and its font ROM.
package vga_timing_pkg;

   // Horizontal timing, in pixel ticks
   localparam int H_ACTIVE     = 640;
   localparam int H_FP         = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BP         = 48;
   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

   // Vertical timing, in lines
   localparam int V_ACTIVE     = 480;
   localparam int V_FP         = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BP         = 33;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   // Character cell geometry
   localparam int GLYPH_W      = 8;
   localparam int GLYPH_H      = 8;
   localparam int GLYPH_SHIFT  = $clog2(GLYPH_W);
   localparam int COLS         = H_ACTIVE / GLYPH_W;
   localparam int ROWS         = V_ACTIVE / GLYPH_H;

   // Datapath widths
   localparam int CNT_W        = 10;
   localparam int CODE_W       = 7;
   localparam int ROW_W        = 8;
   localparam int ROM_AW       = CODE_W + $clog2(GLYPH_H);
   localparam int ROM_DEPTH    = 1 << ROM_AW;

   typedef logic [CNT_W-1:0]       cnt_t;
   typedef logic [CODE_W-1:0]      code_t;
   typedef logic [GLYPH_SHIFT-1:0] sub_t;

   // Everything captured from the counters and the display RAM on one tick.
   // raw_h / raw_v are the sync levels before output registering (1 = idle).
   typedef struct packed {
      code_t code;
      sub_t  col;
      sub_t  line;
      logic  active;
      logic  raw_h;
      logic  raw_v;
   } glyph_stage_t;

   // Active-low sync level: low only inside [start, stop).
   function automatic logic sync_level(input cnt_t count, input int start, input int stop);
      return !((int'(count) >= start) && (int'(count) < stop));
   endfunction

endpackage

// File: rtl/glyph_font_rom.sv
// 1024x8 font ROM: one 8-bit pixel row per {character code, glyph line}.
// Synchronous read with one cycle of latency, advancing only when enabled.
module glyph_font_rom
   import vga_timing_pkg::*;
#(
   parameter bit LOAD_FONT = 1'b1
) (
   input  logic              clk,
   input  logic              en,
   input  logic [ROM_AW-1:0] addr,
   output logic [ROW_W-1:0]  row
);

   logic [ROW_W-1:0] mem [0:ROM_DEPTH-1];

   generate
      if (LOAD_FONT) begin : g_load
         initial begin
            for (int i = 0; i < ROM_DEPTH; i++) begin
               if ((i % GLYPH_H == 0) || (i % GLYPH_H == GLYPH_H - 1)) begin
                  mem[i] = 8'hFF;
               end else begin
                  mem[i] = 8'h81 | (8'h80 >> (i % GLYPH_H));
               end
            end
         end
      end
   endgenerate

   // Registered read, held between pixel ticks
   always_ff @(posedge clk) begin
      if (en) begin
         row <= mem[addr];
      end
   end

endmodule

// File: rtl/vga_glyph_renderer.sv
// Text-mode VGA front end: pixel-tick divider, raster counters, glyph
// address generation for the display RAM, and a 3-tick pipeline
// (capture -> font ROM -> pixel) that keeps syncs aligned with pixels.
module vga_glyph_renderer
   import vga_timing_pkg::*;
#(
   parameter int         CLK_DIV   = 2,
   parameter int         H_ACTIVE  = vga_timing_pkg::H_ACTIVE,
   parameter int         H_FP      = vga_timing_pkg::H_FP,
   parameter int         H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int         H_BP      = vga_timing_pkg::H_BP,
   parameter int         V_ACTIVE  = vga_timing_pkg::V_ACTIVE,
   parameter int         V_FP      = vga_timing_pkg::V_FP,
   parameter int         V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int         V_BP      = vga_timing_pkg::V_BP,
   parameter logic [7:0] FG_COLOR  = 8'hFF,
   parameter logic [7:0] BG_COLOR  = 8'h00,
   parameter bit         LOAD_FONT = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CODE_W-1:0] charCode,
   output logic [7:0]        hGlyphVGA,
   output logic [6:0]        vGlyphVGA,
   output logic              hSync,
   output logic              vSync,
   output logic [7:0]        rgb,
   output logic              frameStart
);

   localparam int LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START    = H_ACTIVE + H_FP;
   localparam int HS_STOP     = HS_START + H_SYNC;
   localparam int VS_START    = V_ACTIVE + V_FP;
   localparam int VS_STOP     = VS_START + V_SYNC;
   localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   cnt_t             h_count;
   cnt_t             v_count;
   logic             h_last;
   logic             v_last;
   logic             active;

   glyph_stage_t     s0;
   sub_t             s1_col;
   logic             s1_active;
   logic             s1_raw_h;
   logic             s1_raw_v;
   logic [ROW_W-1:0] font_row;
   logic             pix_bit;

   assign tick   = (div_cnt == DIV_LAST);
   assign h_last = (int'(h_count) == LINE_LEN - 1);
   assign v_last = (int'(v_count) == FRAME_LINES - 1);
   assign active = (int'(h_count) < H_ACTIVE) && (int'(v_count) < V_ACTIVE);

   // Pixel tick divider: one tick every CLK_DIV system clocks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Raster counters; on the last pixel of the last line both wrap together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (tick) begin
         if (h_last) begin
            h_count <= '0;
            if (v_last) begin
               v_count <= '0;
            end else begin
               v_count <= v_count + 1'b1;
            end
         end else begin
            h_count <= h_count + 1'b1;
         end
      end
   end

   // Frame marker follows the counter wrap directly, not the pixel pipeline
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frameStart <= 1'b0;
      end else begin
         frameStart <= tick && h_last && v_last;
      end
   end

   // Cell address for the display RAM, parked at 0 during blanking
   always_comb begin
      hGlyphVGA = '0;
      vGlyphVGA = '0;
      if (active) begin
         hGlyphVGA = {1'b0, h_count[CNT_W-1:GLYPH_SHIFT]};
         vGlyphVGA = {1'b0, v_count[CNT_W-2:GLYPH_SHIFT]};
      end
   end

   // Stage 0: capture the returned code with the position and sync levels.
   // Sync levels reset to idle so no sync pulse leaks out while the pipe fills.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0 <= '{code: '0, col: '0, line: '0, active: 1'b0, raw_h: 1'b1, raw_v: 1'b1};
      end else if (tick) begin
         s0 <= '{code:   charCode,
                 col:    h_count[GLYPH_SHIFT-1:0],
                 line:   v_count[GLYPH_SHIFT-1:0],
                 active: active,
                 raw_h:  sync_level(h_count, HS_START, HS_STOP),
                 raw_v:  sync_level(v_count, VS_START, VS_STOP)};
      end
   end

   glyph_font_rom #(
      .LOAD_FONT (LOAD_FONT)
   ) u_rom (
      .clk  (clk),
      .en   (tick),
      .addr ({s0.code, s0.line}),
      .row  (font_row)
   );

   // Stage 1: carry column, active and sync alongside the ROM read
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_col    <= '0;
         s1_active <= 1'b0;
         s1_raw_h  <= 1'b1;
         s1_raw_v  <= 1'b1;
      end else if (tick) begin
         s1_col    <= s0.col;
         s1_active <= s0.active;
         s1_raw_h  <= s0.raw_h;
         s1_raw_v  <= s0.raw_v;
      end
   end

   // Leftmost pixel of a cell is the MSB of the font row
   assign pix_bit = font_row[3'd7 - s1_col];

   // Stage 2: pixel colour and syncs registered together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb   <= 8'h00;
         hSync <= 1'b1;
         vSync <= 1'b1;
      end else if (tick) begin
         rgb   <= s1_active ? (pix_bit ? FG_COLOR : BG_COLOR) : 8'h00;
         hSync <= s1_raw_h;
         vSync <= s1_raw_v;
      end
   end

endmodule

// File: tb/tb_vga_glyph_renderer.sv
// Bench for vga_glyph_renderer on a reduced raster (200x48 ticks) so that
// sync pulses and several frame wraps fit in a short run.
module tb_vga_glyph_renderer;

   localparam int CLK_DIV = 2;
   localparam int H_ACT   = 160;
   localparam int H_FPW   = 8;
   localparam int H_SYW   = 16;
   localparam int H_BPW   = 16;
   localparam int V_ACT   = 40;
   localparam int V_FPW   = 2;
   localparam int V_SYW   = 2;
   localparam int V_BPW   = 4;
   localparam int LINE    = H_ACT + H_FPW + H_SYW + H_BPW;
   localparam int LINES   = V_ACT + V_FPW + V_SYW + V_BPW;
   localparam int FRAME   = LINE * LINES;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] charCode;
   logic [7:0] hGlyphVGA;
   logic [6:0] vGlyphVGA;
   logic       hSync;
   logic       vSync;
   logic [7:0] rgb;
   logic       frameStart;

   logic [6:0] screen [0:127][0:255];
   logic [7:0] font   [0:1023];

   typedef struct packed {
      logic [7:0] rgb;
      logic       hs;
      logic       vs;
   } pix_t;

   pix_t       pipe_q[$];
   pix_t       exp_pix;
   logic       exp_fs;
   int         compared   = 0;
   int         mismatched = 0;
   int         k;
   int         cur;
   int         last_fs;
   int         frames_seen;
   int         hs_low;
   int         vs_low;
   logic [7:0] seq4 [0:7];
   logic [7:0] seq6 [0:7];

   vga_glyph_renderer #(
      .CLK_DIV   (CLK_DIV),
      .H_ACTIVE  (H_ACT),
      .H_FP      (H_FPW),
      .H_SYNC    (H_SYW),
      .H_BP      (H_BPW),
      .V_ACTIVE  (V_ACT),
      .V_FP      (V_FPW),
      .V_SYNC    (V_SYW),
      .V_BP      (V_BPW),
      .FG_COLOR  (8'hFF),
      .BG_COLOR  (8'h00),
      .LOAD_FONT (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .charCode   (charCode),
      .hGlyphVGA  (hGlyphVGA),
      .vGlyphVGA  (vGlyphVGA),
      .hSync      (hSync),
      .vSync      (vSync),
      .rgb        (rgb),
      .frameStart (frameStart)
   );

   always #5 clk = ~clk;

   // Display RAM with asynchronous read
   always_comb charCode = screen[vGlyphVGA][hGlyphVGA];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // What the screen should show for raster position c (ticks since frame origin)
   function automatic pix_t model_pixel(input int c);
      int         h;
      int         v;
      int         ci;
      logic       act;
      logic [7:0] fr;
      pix_t       p;
      h   = c % LINE;
      v   = (c / LINE) % LINES;
      act = (h < H_ACT) && (v < V_ACT);
      ci  = act ? int'(screen[7'(v / 8)][8'(h / 8)]) : int'(screen[0][0]);
      fr  = font[10'(ci * 8 + v % 8)];
      p.rgb = act ? (fr[3'(7 - h % 8)] ? 8'hFF : 8'h00) : 8'h00;
      p.hs  = !((h >= H_ACT + H_FPW) && (h < H_ACT + H_FPW + H_SYW));
      p.vs  = !((v >= V_ACT + V_FPW) && (v < V_ACT + V_FPW + V_SYW));
      return p;
   endfunction

   task automatic clear_model();
      k = 0;
      cur = 0;
      pipe_q.delete();
      exp_pix = '{rgb: 8'h00, hs: 1'b1, vs: 1'b1};
      exp_fs = 1'b0;
      last_fs = -1;
      frames_seen = 0;
      hs_low = 0;
      vs_low = 0;
   endtask

   // One system clock: advance the model, then compare every output
   task automatic step();
      int   h;
      int   v;
      logic act;
      @(negedge clk);
      k++;
      cur = k / CLK_DIV;
      if (k % CLK_DIV == 0) begin
         pipe_q.push_back(model_pixel(cur - 1));
         if (pipe_q.size() > 3) void'(pipe_q.pop_front());
         if (pipe_q.size() == 3) exp_pix = pipe_q[0];
         exp_fs = (((cur - 1) % FRAME) == FRAME - 1);
      end else begin
         exp_fs = 1'b0;
      end
      h   = cur % LINE;
      v   = (cur / LINE) % LINES;
      act = (h < H_ACT) && (v < V_ACT);
      check("h_glyph", 32'(hGlyphVGA), act ? h / 8 : 0);
      check("v_glyph", 32'(vGlyphVGA), act ? v / 8 : 0);
      check("rgb", 32'(rgb), 32'(exp_pix.rgb));
      check("hsync", 32'(hSync), 32'(exp_pix.hs));
      check("vsync", 32'(vSync), 32'(exp_pix.vs));
      check("frame_start", 32'(frameStart), 32'(exp_fs));
      if (frameStart) begin
         if (last_fs >= 0) check("frame_gap", cur - last_fs, FRAME);
         last_fs = cur;
         frames_seen++;
      end
      if (!hSync) hs_low++;
      else begin
         if (hs_low != 0) check("hsync_width", hs_low, H_SYW * CLK_DIV);
         hs_low = 0;
      end
      if (!vSync) vs_low++;
      else begin
         if (vs_low != 0) check("vsync_width", vs_low, V_SYW * LINE * CLK_DIV);
         vs_low = 0;
      end
   endtask

   // Step until the raster counter reads target, with random CPU writes
   task automatic run_to(input int target);
      int r;
      int c;
      for (int n = 0; n < 4 * FRAME * CLK_DIV && cur != target; n++) begin
         step();
         if (cur != target && $urandom_range(63) == 0) begin
            r = $urandom_range(V_ACT / 8 - 1);
            c = $urandom_range(H_ACT / 8 - 1);
            if (!(r == 0 && c == 2)) screen[7'(r)][8'(c)] = 7'($urandom_range(127));
         end
      end
      check("run_to_reached", cur, target);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_rgb"}, 32'(rgb), 32'h0);
      check({tag, "_hsync"}, 32'(hSync), 32'h1);
      check({tag, "_vsync"}, 32'(vSync), 32'h1);
      check({tag, "_frame_start"}, 32'(frameStart), 32'h0);
      check({tag, "_h_glyph"}, 32'(hGlyphVGA), 32'h0);
      check({tag, "_v_glyph"}, 32'(vGlyphVGA), 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      clear_model();
      seq4 = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
      seq6 = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
      for (int r = 0; r < 128; r++)
         for (int c = 0; c < 256; c++)
            screen[r][c] = 7'($urandom_range(127));
      for (int i = 0; i < 1024; i++) font[i] = 8'($urandom_range(255));
      font[10'(65 * 8 + 3)] = 8'b0011_1100;
      font[10'(90 * 8 + 3)] = 8'b1100_0011;
      screen[0][2] = 7'h41;
      for (int i = 0; i < 1024; i++) dut.u_rom.mem[10'(i)] = font[i];

      repeat (2) @(negedge clk);
      reset_checks("por");
      reset = 1'b0;

      run_to(20 * LINE + 100);
      reset = 1'b1;
      @(negedge clk);
      reset_checks("mid_reset");
      reset = 1'b0;
      clear_model();

      for (int i = 0; i < 8; i++) begin
         run_to(3 * LINE + 16 + 3 + i);
         check("glyph41_row3", 32'(rgb), 32'(seq4[i]));
      end

      run_to(39 * LINE + 159);
      check("h_glyph_last", 32'(hGlyphVGA), 19);
      check("v_glyph_last", 32'(vGlyphVGA), 4);
      run_to(FRAME + 160);
      check("h_glyph_blank", 32'(hGlyphVGA), 0);
      check("v_glyph_blank", 32'(vGlyphVGA), 0);
      run_to(FRAME + 163);
      check("rgb_blank", 32'(rgb), 0);

      for (int i = 0; i < 8; i++) begin
         run_to(FRAME + 3 * LINE + 16 + 3 + i);
         check("glyph_swap", 32'(rgb), 32'(seq6[i]));
         if (i == 1) screen[0][2] = 7'h5A;
      end

      run_to(2 * FRAME + 400);
      check("frames_seen", frames_seen, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
